ann_sample_scheduler: RTL
=========================

Name: ann_sample_scheduler

Overview:
- Sequences a stored dataset through the ANN datapath (input_vector / desired_output / train / done / valid interface).
- Each pass fetches one sample from an external sample memory and launches it with a one-cycle ann_done pulse. It then waits for ann_valid and scores the result.
- Loops over all samples for a programmed number of epochs in train mode, or exactly one pass in inference mode.
- Sits between the host/config logic and the network wrapper.

Parameters:
- NUM_SAMPLES, 16: samples per epoch; addresses 0..NUM_SAMPLES-1.
- AW, 4: sample memory address width; must satisfy 2^AW >= NUM_SAMPLES.
- VEC_W, 64: packed width of the input vector, the desired vector and the result vector.
- EPOCH_W, 16: epoch counter width.
- TIMEOUT, 1023: maximum BUSY cycles per sample before an error is raised.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- abort  in  1  return to IDLE at the next edge from any state except IDLE.
- cfg_train  in  1  1 = training run, 0 = inference; latched at start.
- cfg_epochs  in  EPOCH_W  epoch count; latched at start; 0 is treated as 1.
- mem_rd  out  1  sample memory read strobe.
- mem_addr  out  AW  sample index.
- mem_rdata_in  in  VEC_W  input vector; valid the cycle after mem_rd.
- mem_rdata_des  in  VEC_W  desired vector; valid the cycle after mem_rd.
- ann_input  out  VEC_W  registered input vector driven to the network.
- ann_desired  out  VEC_W  registered desired vector driven to the network.
- ann_train  out  1  train flag to the network; equals the latched cfg_train.
- ann_done  out  1  one-cycle launch pulse to the network.
- ann_valid  in  1  network finished the current sample.
- ann_result  in  VEC_W  network output; sampled when ann_valid=1 in BUSY.
- busy  out  1  high in every state except IDLE.
- run_done  out  1  one-cycle pulse at the end of a completed run.
- timeout_err  out  1  sticky; cleared by the next accepted start or by RST.
- epoch_cnt  out  EPOCH_W  completed epochs.
- mismatch_cnt  out  AW+EPOCH_W  number of samples with ann_result != desired (all epochs).

Behaviour:
- Reset (RST=1 at an edge): state=IDLE; every output and internal register = 0.
- States: IDLE, FETCH, CAPTURE, LAUNCH, BUSY, CHECK.
- IDLE:
  - On start: latch cfg_train and max(cfg_epochs,1); clear sample_idx, epoch_cnt, mismatch_cnt and timeout_err; go to FETCH.
  - A start in any other state is ignored.
- FETCH (1 cycle): mem_rd=1, mem_addr=sample_idx; go to CAPTURE.
- CAPTURE (1 cycle): register mem_rdata_in into ann_input and mem_rdata_des into ann_desired; go to LAUNCH.
- LAUNCH (1 cycle): ann_done=1; clear the timeout counter; go to BUSY.
- BUSY:
  - ann_valid is sampled only in this state; ann_valid asserted during LAUNCH is ignored.
  - On ann_valid=1: capture ann_result; go to CHECK.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT with no ann_valid: set timeout_err, go to IDLE, no run_done pulse.
  - Response latency 0 (ann_valid in the first BUSY cycle) is legal.
- CHECK (1 cycle):
  - If the captured result != ann_desired, increment mismatch_cnt; it saturates at all-ones.
  - If sample_idx == NUM_SAMPLES-1: sample_idx=0 and epoch_cnt++.
    - If epoch_cnt+1 == latched epochs: pulse run_done and go to IDLE.
    - Else go to FETCH.
  - Otherwise sample_idx++ and go to FETCH.
- Inference mode always runs exactly one epoch, regardless of cfg_epochs.
- Per-sample cost: 4 cycles + network latency + 1 (BUSY exit).
- abort and RST in the same cycle: RST wins.
- abort: next state IDLE; counters hold their values; no run_done pulse; ann_done, mem_rd and busy are low from the next cycle.
- ann_input and ann_desired hold their value between samples; they change only in CAPTURE.
- cfg_* inputs are ignored except in the start cycle.

Test Plan:
- NUM_SAMPLES=4, cfg_train=1, cfg_epochs=2, network model asserts valid 3 cycles after ann_done, result==desired -> mem_addr sequence 0,1,2,3,0,1,2,3; 8 ann_done pulses; run_done at the final CHECK; epoch_cnt=2; mismatch_cnt=0.
- cfg_train=0, cfg_epochs=5, model returns a wrong result for samples 1 and 3 -> single epoch only; epoch_cnt=1; mismatch_cnt=2; ann_train=0 throughout.
- Model never asserts valid, TIMEOUT=1023 -> timeout_err=1 exactly 1023 BUSY cycles after LAUNCH; state IDLE; no run_done; a new start clears timeout_err.
- abort asserted in BUSY of sample 2 -> busy=0 next cycle; no run_done; epoch_cnt=0; a later start runs normally from sample 0.
- start asserted mid-run and ann_valid asserted during LAUNCH -> both ignored; sequence unchanged; the sample completes only on valid in BUSY.
- RST asserted in CAPTURE -> all outputs 0 at the next edge; the following start behaves like the first run.

Source files
------------

// File: rtl/ann_sample_scheduler.sv
// Steps a stored dataset through the ANN datapath. Each sample is fetched, launched,
// and scored. Train mode repeats this for the latched number of epochs; inference runs one pass.
module ann_sample_scheduler #(
  parameter int NUM_SAMPLES = 16,
  parameter int AW          = 4,
  parameter int VEC_W       = 64,
  parameter int EPOCH_W     = 16,
  parameter int TIMEOUT     = 1023
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cfg_train,
  input  logic [EPOCH_W-1:0]    cfg_epochs,
  output logic                  mem_rd,
  output logic [AW-1:0]         mem_addr,
  input  logic [VEC_W-1:0]      mem_rdata_in,
  input  logic [VEC_W-1:0]      mem_rdata_des,
  output logic [VEC_W-1:0]      ann_input,
  output logic [VEC_W-1:0]      ann_desired,
  output logic                  ann_train,
  output logic                  ann_done,
  input  logic                  ann_valid,
  input  logic [VEC_W-1:0]      ann_result,
  output logic                  busy,
  output logic                  run_done,
  output logic                  timeout_err,
  output logic [EPOCH_W-1:0]    epoch_cnt,
  output logic [AW+EPOCH_W-1:0] mismatch_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MW = AW + EPOCH_W;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SAMPLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_LAUNCH  = 3'd3,
    S_BUSY    = 3'd4,
    S_CHECK   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 train_q, train_d;
  logic [EPOCH_W-1:0]   epochs_q, epochs_d;
  logic [AW-1:0]        sample_idx_q, sample_idx_d;
  logic [EPOCH_W-1:0]   epoch_cnt_q, epoch_cnt_d;
  logic [MW-1:0]        mismatch_cnt_q, mismatch_cnt_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [VEC_W-1:0]     ann_input_q, ann_input_d;
  logic [VEC_W-1:0]     ann_desired_q, ann_desired_d;
  logic [VEC_W-1:0]     result_q, result_d;
  logic                 mem_rd_q, mem_rd_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic                 ann_done_q, ann_done_d;
  logic                 run_done_q, run_done_d;
  logic                 busy_q, busy_d;

  // Next-state logic; strobes are decoded from the next state so they align with it.
  always_comb begin
    state_d        = state_q;
    train_d        = train_q;
    epochs_d       = epochs_q;
    sample_idx_d   = sample_idx_q;
    epoch_cnt_d    = epoch_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    timeout_err_d  = timeout_err_q;
    tmo_cnt_d      = tmo_cnt_q;
    ann_input_d    = ann_input_q;
    ann_desired_d  = ann_desired_q;
    result_d       = result_q;
    run_done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          train_d = cfg_train;
          if (!cfg_train || (cfg_epochs == {EPOCH_W{1'b0}})) begin
            epochs_d = EPOCH_W'(1);
          end else begin
            epochs_d = cfg_epochs;
          end
          sample_idx_d   = {AW{1'b0}};
          epoch_cnt_d    = {EPOCH_W{1'b0}};
          mismatch_cnt_d = {MW{1'b0}};
          timeout_err_d  = 1'b0;
          state_d        = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        ann_input_d   = mem_rdata_in;
        ann_desired_d = mem_rdata_des;
        state_d       = S_LAUNCH;
      end
      S_LAUNCH: begin
        tmo_cnt_d = {TW{1'b0}};
        state_d   = S_BUSY;
      end
      S_BUSY: begin
        if (ann_valid) begin
          result_d = ann_result;
          state_d  = S_CHECK;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_CHECK: begin
        if ((result_q != ann_desired_q) && (mismatch_cnt_q != {MW{1'b1}})) begin
          mismatch_cnt_d = mismatch_cnt_q + MW'(1);
        end else begin
          mismatch_cnt_d = mismatch_cnt_q;
        end
        if (sample_idx_q == LAST_IDX) begin
          sample_idx_d = {AW{1'b0}};
          epoch_cnt_d  = epoch_cnt_q + EPOCH_W'(1);
          if ((epoch_cnt_q + EPOCH_W'(1)) == epochs_q) begin
            run_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          sample_idx_d = sample_idx_q + AW'(1);
          state_d      = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort freezes all progress counters where they stand.
    if (abort && (state_q != S_IDLE)) begin
      state_d        = S_IDLE;
      run_done_d     = 1'b0;
      sample_idx_d   = sample_idx_q;
      epoch_cnt_d    = epoch_cnt_q;
      mismatch_cnt_d = mismatch_cnt_q;
      timeout_err_d  = timeout_err_q;
    end else begin
      state_d = state_d;
    end

    mem_rd_d   = (state_d == S_FETCH);
    ann_done_d = (state_d == S_LAUNCH);
    busy_d     = (state_d != S_IDLE);
    if (state_d == S_FETCH) begin
      mem_addr_d = sample_idx_d;
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      train_q        <= 1'b0;
      epochs_q       <= {EPOCH_W{1'b0}};
      sample_idx_q   <= {AW{1'b0}};
      epoch_cnt_q    <= {EPOCH_W{1'b0}};
      mismatch_cnt_q <= {MW{1'b0}};
      timeout_err_q  <= 1'b0;
      tmo_cnt_q      <= {TW{1'b0}};
      ann_input_q    <= {VEC_W{1'b0}};
      ann_desired_q  <= {VEC_W{1'b0}};
      result_q       <= {VEC_W{1'b0}};
      mem_rd_q       <= 1'b0;
      mem_addr_q     <= {AW{1'b0}};
      ann_done_q     <= 1'b0;
      run_done_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      train_q        <= train_d;
      epochs_q       <= epochs_d;
      sample_idx_q   <= sample_idx_d;
      epoch_cnt_q    <= epoch_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      timeout_err_q  <= timeout_err_d;
      tmo_cnt_q      <= tmo_cnt_d;
      ann_input_q    <= ann_input_d;
      ann_desired_q  <= ann_desired_d;
      result_q       <= result_d;
      mem_rd_q       <= mem_rd_d;
      mem_addr_q     <= mem_addr_d;
      ann_done_q     <= ann_done_d;
      run_done_q     <= run_done_d;
      busy_q         <= busy_d;
    end
  end

  assign mem_rd       = mem_rd_q;
  assign mem_addr     = mem_addr_q;
  assign ann_input    = ann_input_q;
  assign ann_desired  = ann_desired_q;
  assign ann_train    = train_q;
  assign ann_done     = ann_done_q;
  assign busy         = busy_q;
  assign run_done     = run_done_q;
  assign timeout_err  = timeout_err_q;
  assign epoch_cnt    = epoch_cnt_q;
  assign mismatch_cnt = mismatch_cnt_q;

endmodule
